// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
// Covers state encodings, register/NOP constants and the control output bundle.
package pipe_ctrl_pkg;

    localparam logic [1:0]  ST_RUN      = 2'd0;
    localparam logic [1:0]  ST_LD_STALL = 2'd1;
    localparam logic [1:0]  ST_DIV_WAIT = 2'd2;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [4:0]  ZERO_REG    = 5'd0;

    typedef struct packed {
        logic        pc_hold;
        logic        pc_redirect;
        logic [31:0] pc_target;
        logic        if_id_hold;
        logic        if_id_flush;
        logic        id_ex_hold;
        logic        id_ex_flush;
    } ctrl_out_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Event inputs and pipeline-steering outputs of the sequencing controller.
// The master side is the core datapath; the slave side is pipe_ctrl.
interface pipe_ctrl_if;

    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        ex_load;
    logic [4:0]  ex_rd;
    logic        ex_jump;
    logic [31:0] ex_jump_addr;
    logic        ex_div_start;
    logic        div_busy;

    logic        pc_hold;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic        if_id_hold;
    logic        if_id_flush;
    logic        id_ex_hold;
    logic        id_ex_flush;
    logic        div_timeout;
    logic [1:0]  state;

    modport master (
        output id_rs1, id_rs2, ex_load, ex_rd, ex_jump, ex_jump_addr, ex_div_start, div_busy,
        input  pc_hold, pc_redirect, pc_target, if_id_hold, if_id_flush,
               id_ex_hold, id_ex_flush, div_timeout, state
    );

    modport slave (
        input  id_rs1, id_rs2, ex_load, ex_rd, ex_jump, ex_jump_addr, ex_div_start, div_busy,
        output pc_hold, pc_redirect, pc_target, if_id_hold, if_id_flush,
               id_ex_hold, id_ex_flush, div_timeout, state
    );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use compare between the load in EX and the operands being decoded.
// Purely combinational so the forwarding unit can share it.
module pipe_ctrl_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       ex_load,
    input  logic [4:0] ex_rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    output logic       haz
);

    assign haz = ex_load && (ex_rd != ZERO_REG) && ((ex_rd == rs1) || (ex_rd == rs2));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, jump flushes, divide stalls
// and a watchdog on the divider busy handshake.
//
// state       | meaning
// ST_RUN      | normal issue; jump > div_start > load-use
// ST_LD_STALL | one-cycle bubble after a load-use stall
// ST_DIV_WAIT | EX frozen until div_busy falls or the watchdog expires
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_TIMEOUT = 40,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);

    logic [1:0]       state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             timeout_q, timeout_nxt;
    logic             haz;
    ctrl_out_t        ctl;

    pipe_ctrl_hazard_detect u_haz (
        .ex_load (bus.ex_load),
        .ex_rd   (bus.ex_rd),
        .rs1     (bus.id_rs1),
        .rs2     (bus.id_rs2),
        .haz     (haz)
    );

    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        timeout_nxt = timeout_q;
        ctl         = '0;
        case (state_q)
            ST_RUN: begin
                if (bus.ex_jump) begin
                    ctl.pc_redirect = 1'b1;
                    ctl.pc_target   = bus.ex_jump_addr;
                    ctl.if_id_flush = 1'b1;
                    ctl.id_ex_flush = 1'b1;
                end else if (bus.ex_div_start) begin
                    ctl.pc_hold    = 1'b1;
                    ctl.if_id_hold = 1'b1;
                    ctl.id_ex_hold = 1'b1;
                    state_nxt      = ST_DIV_WAIT;
                    cnt_nxt        = '0;
                end else if (haz) begin
                    ctl.pc_hold     = 1'b1;
                    ctl.if_id_hold  = 1'b1;
                    ctl.id_ex_flush = 1'b1;
                    state_nxt       = ST_LD_STALL;
                end
            end
            ST_LD_STALL: state_nxt = ST_RUN;
            ST_DIV_WAIT: begin
                if (bus.div_busy) begin
                    ctl.pc_hold    = 1'b1;
                    ctl.if_id_hold = 1'b1;
                    ctl.id_ex_hold = 1'b1;
                    // This busy cycle is the DIV_TIMEOUT-th one: give up and release.
                    if (cnt_q >= CNT_W'(DIV_TIMEOUT - 1)) begin
                        cnt_nxt     = CNT_W'(DIV_TIMEOUT);
                        timeout_nxt = 1'b1;
                        state_nxt   = ST_RUN;
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    // Quiet the pipeline while reset is held, whatever the event inputs show.
    assign bus.pc_hold     = ctl.pc_hold     & ~rst;
    assign bus.pc_redirect = ctl.pc_redirect & ~rst;
    assign bus.pc_target   = rst ? 32'd0 : ctl.pc_target;
    assign bus.if_id_hold  = ctl.if_id_hold  & ~rst;
    assign bus.if_id_flush = ctl.if_id_flush & ~rst;
    assign bus.id_ex_hold  = ctl.id_ex_hold  & ~rst;
    assign bus.id_ex_flush = ctl.id_ex_flush & ~rst;
    assign bus.div_timeout = timeout_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and randomized checks of pipe_ctrl against a flag-level reference model.
module tb_pipe_ctrl;

    localparam int DIV_TIMEOUT = 40;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   hold_cnt;
    int   wait_cnt;

    bit   m_stall;
    bit   m_div;
    int   m_cycles;
    bit   m_tmo;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.DIV_TIMEOUT(DIV_TIMEOUT), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit haz_ref();
        return bus.ex_load && bus.ex_rd != 0 && (bus.ex_rd == bus.id_rs1 || bus.ex_rd == bus.id_rs2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        bit        e_ph, e_rd, e_ifh, e_iff, e_exh, e_exf;
        logic [31:0] e_tgt;
        e_ph = 0; e_rd = 0; e_ifh = 0; e_iff = 0; e_exh = 0; e_exf = 0; e_tgt = 0;
        if (rst) begin
        end else if (m_div) begin
            if (bus.div_busy) begin e_ph = 1; e_ifh = 1; e_exh = 1; end
        end else if (m_stall) begin
        end else if (bus.ex_jump) begin
            e_rd = 1; e_tgt = bus.ex_jump_addr; e_iff = 1; e_exf = 1;
        end else if (bus.ex_div_start) begin
            e_ph = 1; e_ifh = 1; e_exh = 1;
        end else if (haz_ref()) begin
            e_ph = 1; e_ifh = 1; e_exf = 1;
        end
        chk({tag, ".pc_hold"},     32'(bus.pc_hold),     32'(e_ph));
        chk({tag, ".pc_redirect"}, 32'(bus.pc_redirect), 32'(e_rd));
        chk({tag, ".pc_target"},   bus.pc_target,        e_tgt);
        chk({tag, ".if_id_hold"},  32'(bus.if_id_hold),  32'(e_ifh));
        chk({tag, ".if_id_flush"}, 32'(bus.if_id_flush), 32'(e_iff));
        chk({tag, ".id_ex_hold"},  32'(bus.id_ex_hold),  32'(e_exh));
        chk({tag, ".id_ex_flush"}, 32'(bus.id_ex_flush), 32'(e_exf));
        chk({tag, ".div_timeout"}, 32'(bus.div_timeout), 32'(m_tmo));
        chk({tag, ".state"},       32'(bus.state),       m_div ? 32'd2 : (m_stall ? 32'd1 : 32'd0));
    endtask

    task automatic model_edge();
        if (rst) begin
            m_stall = 0; m_div = 0; m_cycles = 0; m_tmo = 0;
        end else if (m_div) begin
            if (bus.div_busy) begin
                m_cycles++;
                if (m_cycles == DIV_TIMEOUT) begin m_tmo = 1; m_div = 0; end
            end else begin
                m_div = 0;
            end
        end else if (m_stall) begin
            m_stall = 0;
        end else if (bus.ex_jump) begin
        end else if (bus.ex_div_start) begin
            m_div = 1; m_cycles = 0;
        end else if (haz_ref()) begin
            m_stall = 1;
        end
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        check_all(tag);
        if (bus.pc_hold && bus.if_id_hold && bus.id_ex_hold) hold_cnt++;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_rs1 = 0; bus.id_rs2 = 0; bus.ex_load = 0; bus.ex_rd = 0;
        bus.ex_jump = 0; bus.ex_jump_addr = 0; bus.ex_div_start = 0; bus.div_busy = 0;
    endtask

    initial begin
        checks = 0; errors = 0; hold_cnt = 0;
        m_stall = 0; m_div = 0; m_cycles = 0; m_tmo = 0;
        idle_inputs();
        rst = 1;
        bus.ex_jump = 1; bus.ex_jump_addr = 32'hdead_beef;
        step("reset");
        step("reset2");
        rst = 0;
        idle_inputs();
        step("idle");

        bus.ex_load = 1; bus.ex_rd = 5; bus.id_rs2 = 5; bus.id_rs1 = 7;
        step("ldu_stall");
        step("ldu_bubble");
        step("ldu_again");
        step("ldu_bubble2");

        idle_inputs();
        bus.ex_load = 1; bus.ex_rd = 0; bus.id_rs1 = 0;
        step("x0_load");

        idle_inputs();
        bus.ex_load = 1; bus.ex_rd = 9; bus.id_rs1 = 9;
        bus.ex_jump = 1; bus.ex_jump_addr = 32'h0000_0100; bus.ex_div_start = 1;
        step("jump_haz");
        idle_inputs();
        step("after_jump");

        hold_cnt = 0;
        bus.ex_div_start = 1; bus.div_busy = 1;
        step("div_start");
        bus.ex_div_start = 0;
        for (int i = 0; i < 33; i++) step("div_busy");
        bus.div_busy = 0;
        step("div_fall");
        chk("div_hold_cycles", hold_cnt, 34);
        bus.ex_div_start = 1; bus.div_busy = 1;
        step("b2b_start");
        bus.ex_div_start = 0; bus.div_busy = 0;
        step("b2b_fall");
        step("b2b_idle");

        bus.ex_div_start = 1; bus.div_busy = 1;
        step("tmo_start");
        bus.ex_div_start = 0;
        wait_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step("tmo_busy");
            wait_cnt++;
            if (bus.div_timeout) break;
        end
        chk("tmo_cycles", wait_cnt, DIV_TIMEOUT);
        for (int i = 0; i < 3; i++) step("tmo_sticky");
        bus.div_busy = 0;
        step("tmo_sticky_idle");

        bus.ex_div_start = 1; bus.div_busy = 1;
        step("rstdiv_start");
        bus.ex_div_start = 0;
        for (int i = 0; i < 9; i++) step("rstdiv_busy");
        rst = 1;
        step("rstdiv_rst");
        rst = 0;
        step("rstdiv_after");
        chk("rstdiv_timeout", 32'(bus.div_timeout), 32'd0);

        for (int i = 0; i < 400; i++) begin
            rst              = ($urandom_range(0, 99) == 0);
            bus.ex_jump      = ($urandom_range(0, 9) == 0);
            bus.ex_jump_addr = $urandom;
            bus.ex_div_start = ($urandom_range(0, 14) == 0);
            bus.div_busy     = ($urandom_range(0, 7) != 0);
            bus.ex_load      = $urandom_range(0, 1) == 1;
            bus.ex_rd        = 5'($urandom_range(0, 3));
            bus.id_rs1       = 5'($urandom_range(0, 3));
            bus.id_rs2       = 5'($urandom_range(0, 3));
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
